pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl.sv | 126 ++++++++++++
 tb/tb_pipeline_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/stall controller: freeze and flush steering for IF/ID, ID/EX and the
// back-end registers, a memory-wait FSM with timeout, and saturating perf counters.
module pipeline_ctrl #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             clr_cnt,
  output logic             freeze_if,
  output logic             flush_if,
  output logic             freeze_id,
  output logic             flush_id,
  output logic             freeze_back,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned WAIT_W = 8;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_WAIT = 2'd1,
    S_ERR  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [WAIT_W-1:0]   r_wait_cnt;
  logic [WAIT_W-1:0]   w_wait_cnt_nxt;
  logic                r_mem_err;
  logic                w_mem_stall;
  logic                w_hz_eff;
  logic [CNT_W-1:0]    r_stall_cnt;
  logic [CNT_W-1:0]    r_flush_cnt;

  // State and wait-counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_RUN;
      r_wait_cnt <= '0;
      r_mem_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      if (w_state_nxt == S_ERR) begin
        r_mem_err <= 1'b1;
      end
    end
  end

  // Next-state logic and memory stall decode
  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_mem_stall    = 1'b0;
    case (r_state)
      S_RUN: begin
        if (mem_req && !mem_ready) begin
          w_mem_stall    = 1'b1;
          w_state_nxt    = S_WAIT;
          w_wait_cnt_nxt = WAIT_W'(1);
        end
      end
      S_WAIT: begin
        if (mem_ready) begin
          w_state_nxt    = S_RUN;
          w_wait_cnt_nxt = '0;
        end else begin
          w_mem_stall = 1'b1;
          if (r_wait_cnt == WAIT_LAST) begin
            w_state_nxt = S_ERR;
          end else begin
            w_wait_cnt_nxt = r_wait_cnt + WAIT_W'(1);
          end
        end
      end
      S_ERR: begin
        w_mem_stall = 1'b1;
      end
      default: begin
        w_state_nxt    = S_RUN;
        w_wait_cnt_nxt = '0;
      end
    endcase
  end

  // Priority: memory stall over branch over hazard; a stalled EX keeps its branch pending
  always_comb begin
    w_hz_eff    = hazard && !branch_taken && !w_mem_stall;
    freeze_if   = w_mem_stall || w_hz_eff;
    flush_if    = branch_taken && !w_mem_stall;
    freeze_id   = w_mem_stall;
    flush_id    = (branch_taken || hazard) && !w_mem_stall;
    freeze_back = w_mem_stall;
  end

  // Saturating performance counters; clear wins over increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (clr_cnt) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (freeze_if && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (flush_if && (r_flush_cnt != {CNT_W{1'b1}})) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  assign mem_err   = r_mem_err;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: one instance with a short timeout, one with 2-bit
// counters and the default timeout, both driven from the same inputs.
module tb_pipeline_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic hazard, branch_taken, mem_req, mem_ready, clr_cnt;

  logic        freeze_if, flush_if, freeze_id, flush_id, freeze_back, mem_err;
  logic [15:0] stall_cnt, flush_cnt;
  logic        s_freeze_if, s_flush_if, s_freeze_id, s_flush_id, s_freeze_back, s_mem_err;
  logic [1:0]  s_stall_cnt, s_flush_cnt;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.TIMEOUT(4), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .hazard(hazard), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .clr_cnt(clr_cnt),
    .freeze_if(freeze_if), .flush_if(flush_if), .freeze_id(freeze_id),
    .flush_id(flush_id), .freeze_back(freeze_back), .mem_err(mem_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipeline_ctrl #(.TIMEOUT(255), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .hazard(hazard), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .clr_cnt(clr_cnt),
    .freeze_if(s_freeze_if), .flush_if(s_flush_if), .freeze_id(s_freeze_id),
    .flush_id(s_flush_id), .freeze_back(s_freeze_back), .mem_err(s_mem_err),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply inputs, then let combinational outputs settle before checks
  task automatic set_in(input logic h, input logic b, input logic mr, input logic rdy,
                        input logic c);
    hazard = h; branch_taken = b; mem_req = mr; mem_ready = rdy; clr_cnt = c;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0);
    chk("rst_mem_err", 32'(mem_err), 0);
    chk("rst_stall_cnt", 32'(stall_cnt), 0);
    chk("rst_flush_cnt", 32'(flush_cnt), 0);
    chk("rst_freeze_if", 32'(freeze_if), 0);
    // RUN-state combinational behaviour while reset is held
    set_in(1, 0, 0, 0, 0);
    chk("rst_hz_freeze_if", 32'(freeze_if), 1);
    chk("rst_hz_flush_id", 32'(flush_id), 1);
    tick();
    chk("rst_hz_no_count", 32'(stall_cnt), 0);
    rst = 1'b0;
    set_in(0, 0, 0, 0, 0);
    tick();

    // Single hazard cycle
    set_in(1, 0, 0, 0, 0);
    chk("hz_freeze_if", 32'(freeze_if), 1);
    chk("hz_flush_id", 32'(flush_id), 1);
    chk("hz_freeze_id", 32'(freeze_id), 0);
    chk("hz_flush_if", 32'(flush_if), 0);
    tick();
    set_in(0, 0, 0, 0, 0);
    chk("hz_stall_cnt", 32'(stall_cnt), 1);

    // Branch beats hazard
    set_in(1, 1, 0, 0, 0);
    chk("br_flush_if", 32'(flush_if), 1);
    chk("br_flush_id", 32'(flush_id), 1);
    chk("br_freeze_if", 32'(freeze_if), 0);
    tick();
    set_in(0, 0, 0, 0, 0);
    chk("br_flush_cnt", 32'(flush_cnt), 1);
    chk("br_stall_cnt_hold", 32'(stall_cnt), 1);

    // Clear counters
    set_in(0, 0, 0, 0, 1);
    tick();
    set_in(0, 0, 0, 0, 0);
    chk("clr_stall_cnt", 32'(stall_cnt), 0);
    chk("clr_flush_cnt", 32'(flush_cnt), 0);

    // Three-cycle memory wait
    for (int i = 0; i < 3; i++) begin
      set_in(0, 0, 1, 0, 0);
      chk($sformatf("mw_freeze_id_%0d", i), 32'(freeze_id), 1);
      chk($sformatf("mw_freeze_back_%0d", i), 32'(freeze_back), 1);
      tick();
    end
    set_in(0, 0, 1, 1, 0);
    chk("mw_ready_freeze_id", 32'(freeze_id), 0);
    chk("mw_ready_freeze_back", 32'(freeze_back), 0);
    tick();
    set_in(0, 0, 0, 0, 0);
    chk("mw_back_in_run", 32'(freeze_id), 0);
    chk("mw_stall_cnt", 32'(stall_cnt), 3);
    chk("mw_sat_stall_cnt", 32'(s_stall_cnt), 3);

    // Zero-wait access
    set_in(0, 0, 1, 1, 0);
    chk("zw_freeze_id", 32'(freeze_id), 0);
    tick();
    set_in(0, 0, 0, 0, 0);
    chk("zw_still_run", 32'(freeze_id), 0);

    // Branch held off by a memory stall
    for (int i = 0; i < 2; i++) begin
      set_in(0, 1, 1, 0, 0);
      chk($sformatf("bs_flush_if_%0d", i), 32'(flush_if), 0);
      chk($sformatf("bs_flush_id_%0d", i), 32'(flush_id), 0);
      chk($sformatf("bs_freeze_if_%0d", i), 32'(freeze_if), 1);
      tick();
    end
    set_in(0, 1, 1, 1, 0);
    chk("bs_ready_flush_if", 32'(flush_if), 1);
    chk("bs_ready_flush_id", 32'(flush_id), 1);
    chk("bs_ready_freeze_if", 32'(freeze_if), 0);
    tick();
    set_in(0, 0, 0, 0, 0);
    chk("bs_flush_cnt", 32'(flush_cnt), 1);
    chk("bs_stall_cnt", 32'(stall_cnt), 5);
    chk("bs_sat_stall_cnt", 32'(s_stall_cnt), 3);

    // Clear has priority over a simultaneous increment
    set_in(1, 0, 0, 0, 1);
    tick();
    set_in(0, 0, 0, 0, 0);
    chk("clrpri_stall_cnt", 32'(stall_cnt), 0);
    chk("clrpri_sat_stall_cnt", 32'(s_stall_cnt), 0);

    // 2-bit counter saturation
    for (int i = 0; i < 5; i++) begin
      set_in(1, 0, 0, 0, 0);
      tick();
    end
    set_in(0, 0, 0, 0, 0);
    chk("sat_stall_cnt", 32'(s_stall_cnt), 3);
    chk("sat_wide_stall_cnt", 32'(stall_cnt), 5);
    set_in(0, 0, 0, 0, 1);
    tick();
    set_in(0, 0, 0, 0, 0);
    chk("sat_clr", 32'(s_stall_cnt), 0);

    // Memory timeout with TIMEOUT=4
    for (int i = 0; i < 4; i++) begin
      set_in(0, 0, 1, 0, 0);
      chk($sformatf("to_freeze_id_%0d", i), 32'(freeze_id), 1);
      chk($sformatf("to_mem_err_%0d", i), 32'(mem_err), 0);
      tick();
    end
    set_in(0, 1, 1, 0, 0);
    chk("to_err", 32'(mem_err), 1);
    chk("to_err_freeze_id", 32'(freeze_id), 1);
    chk("to_err_freeze_back", 32'(freeze_back), 1);
    chk("to_err_freeze_if", 32'(freeze_if), 1);
    chk("to_err_flush_if", 32'(flush_if), 0);
    chk("to_long_timeout_no_err", 32'(s_mem_err), 0);
    tick();
    set_in(0, 0, 0, 1, 0);
    chk("to_err_sticky", 32'(mem_err), 1);
    chk("to_err_ready_freeze", 32'(freeze_id), 1);
    tick();

    // Asynchronous reset out of ERR and WAIT
    set_in(0, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    chk("ar_mem_err", 32'(mem_err), 0);
    chk("ar_freeze_id", 32'(freeze_id), 0);
    tick();
    rst = 1'b0;
    tick();
    set_in(0, 0, 0, 0, 0);
    chk("ar_run_freeze_id", 32'(freeze_id), 0);
    chk("ar_run_sat_freeze_id", 32'(s_freeze_id), 0);
    chk("ar_stall_cnt", 32'(stall_cnt), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
